hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. Drives the enable (stall) and flush controls of the F/D, D/E, E/M and M/W pipeline registers, generates E-stage forwarding selects, and sequences multi-cycle data-memory waits with a timeout. It also keeps saturating stall and flush performance counters. Pipeline register `en_i` = ~Stall*_o for the matching stage.

## Interface

**Parameters**
- `REG_ADDR_WIDTH`, default 5: register index width.
- `MEM_TIMEOUT`, default 255: maximum memory-stall cycles per access (≥1).
- `CNT_WIDTH`, default 32: width of the performance counters.

**Ports**
- `clk_i` in 1: single clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `Rs1D_i`, `Rs2D_i` in REG_ADDR_WIDTH: Decode-stage source registers.
- `Rs1E_i`, `Rs2E_i`, `RdE_i` in REG_ADDR_WIDTH: Execute-stage sources and destination.
- `LoadE_i` in 1: Execute-stage instruction is a load.
- `PCSrcE_i` in 1: taken branch or jump resolved in E.
- `RdM_i` in REG_ADDR_WIDTH, `RegWriteM_i` in 1: Memory-stage writeback info.
- `RdW_i` in REG_ADDR_WIDTH, `RegWriteW_i` in 1: Writeback-stage writeback info.
- `MemReqM_i` in 1: M-stage instruction accesses data memory.
- `MemReadyM_i` in 1: data memory completes the access this cycle.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o` out 1: hold the corresponding pipeline register.
- `FlushD_o`, `FlushE_o`, `FlushW_o` out 1: insert a bubble into the D/E/W register.
- `ForwardAE_o`, `ForwardBE_o` out 2: 00 = register file, 01 = W result, 10 = M ALU result.
- `MemTimeout_o` out 1: sticky flag; set when any access times out.
- `StallCycles_o` out CNT_WIDTH: count of stalled cycles.
- `FlushCount_o` out CNT_WIDTH: count of redirect flushes.

## Operation

**FSM**
- States: RUN, MEM_WAIT.
- Internal counter `wait_cnt` is 8 bits, sized to hold MEM_TIMEOUT.
- In RUN, `MemReqM_i && !MemReadyM_i` causes a transition to MEM_WAIT and sets `wait_cnt` to 1.
- In MEM_WAIT:
  - `MemReadyM_i` causes a transition to RUN.
  - Otherwise, if `wait_cnt == MEM_TIMEOUT`, set `MemTimeout_o`, go to RUN, and treat the access as complete.
  - Otherwise, `wait_cnt` increments.
- `MemReqM_i` is ignored in MEM_WAIT. It stays high because M is held.

**Memory stall (combinational)**
- `mstall` = (RUN & MemReqM & !MemReadyM) | (MEM_WAIT & !MemReadyM & wait_cnt != MEM_TIMEOUT).

**Load-use stall**
- `lwstall` = LoadE & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).

**Priority, highest first**
1. `mstall`: StallF, StallD, StallE and StallM = 1; FlushW = 1; FlushD and FlushE = 0. A pending PCSrcE or lwstall is held and acted on after release.
2. `PCSrcE_i`: FlushD = FlushE = 1; StallF and StallD = 0.
3. `lwstall`: StallF = StallD = 1; FlushE = 1.
4. Otherwise: all outputs 0.

**Forwarding (A shown; B identical with Rs2E)**
- Select 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
- Else select 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
- Else select 00.
- M has precedence over W. Forwarding is evaluated regardless of stalls.

**Counters**
- `StallCycles_o` increments on any cycle with mstall | lwstall (when PCSrcE does not win).
- `FlushCount_o` increments on cycles with PCSrcE_i & !mstall.
- Both saturate at all-ones.

## Timing

- **Reset:** state RUN, `wait_cnt` 0, `MemTimeout_o` 0, both counters 0. Async assert; deassert is synchronous to `clk_i` via the external reset synchroniser.
- **Combinational outputs:** all stall, flush and forward outputs are combinational from inputs and state, with zero-cycle latency. They are never registered.
- **Ready with request:** `MemReadyM_i` in the same cycle as `MemReqM_i` gives no stall and the FSM stays in RUN.
- **Latency:** ready arriving N cycles after the request gives exactly N stall cycles.
- **Timeout:** with no ready, stall lasts exactly MEM_TIMEOUT cycles. The next cycle has no stall and `MemTimeout_o` is high from the following edge.
- **Simultaneous events:**
  - Ready in the same cycle as `wait_cnt == MEM_TIMEOUT` counts as normal completion; `MemTimeout_o` is not set.
  - PCSrcE together with lwstall resolves to PCSrcE (flush, no stall).
- **Reset mid-wait:** FSM returns to RUN immediately and all stalls drop asynchronously.

## Test plan

- **Load-use:** `LoadE=1`, `RdE=5`, `Rs1D=5`, no memory request → StallF=StallD=FlushE=1 for 1 cycle; `StallCycles_o` goes 0 → 1.
- **Forwarding:** RegWriteM=1, RdM=3; RegWriteW=1, RdW=3; Rs1E=3 → ForwardAE=10. With RdM=0 → ForwardAE=01. With Rs1E=0 and RdW=0 → 00.
- **Memory wait:** MemReqM=1 with ready after 3 cycles → StallF/D/E/M and FlushW high exactly 3 cycles; FSM RUN → MEM_WAIT → RUN; counter = 3.
- **Timeout:** MEM_TIMEOUT=4 and ready never asserted → stall 4 cycles, then released; `MemTimeout_o`=1 and stays high until `rst_ni`=0.
- **Branch during stall:** PCSrcE=1 during a 2-cycle memory stall → FlushD/E = 0 during the stall, then 1 in the release cycle; `FlushCount_o` = 1.
- **Reset mid-wait:** `rst_ni` low in the 2nd MEM_WAIT cycle → all outputs 0 immediately, counters 0; clean RUN behaviour after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the five-stage RV32I core.
//
// Drives the stall (enable) and flush controls of the F/D, D/E, E/M and M/W
// pipeline registers, produces the E-stage forwarding selects, sequences
// multi-cycle data-memory waits with a timeout, and keeps saturating stall and
// flush performance counters. A pipeline register's enable is ~Stall*_o.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   Rs1D_i, Rs2D_i                Decode-stage source registers
//   Rs1E_i, Rs2E_i, RdE_i         Execute-stage sources and destination
//   LoadE_i                       Execute-stage instruction is a load
//   PCSrcE_i                      taken branch/jump resolved in E
//   RdM_i, RegWriteM_i            Memory-stage writeback info
//   RdW_i, RegWriteW_i            Writeback-stage writeback info
//   MemReqM_i, MemReadyM_i        M-stage data-memory request / completion
//   StallF_o..StallM_o            hold the corresponding pipeline register
//   FlushD_o, FlushE_o, FlushW_o  insert a bubble into D/E/W
//   ForwardAE_o, ForwardBE_o      00 regfile, 01 W result, 10 M ALU result
//   MemTimeout_o                  sticky: some access timed out
//   StallCycles_o, FlushCount_o   saturating performance counters
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 255,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic                      LoadE_i,
  input  logic                      PCSrcE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic                      RegWriteM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      RegWriteW_i,
  input  logic                      MemReqM_i,
  input  logic                      MemReadyM_i,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      StallE_o,
  output logic                      StallM_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic                      FlushW_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      MemTimeout_o,
  output logic [CNT_WIDTH-1:0]      StallCycles_o,
  output logic [CNT_WIDTH-1:0]      FlushCount_o
);

  // The wait counter is a fixed 8 bits; MEM_TIMEOUT must fit in it.
  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e                state_q, state_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic mstall, lwstall, branch;
  logic stall_inc, flush_inc;

  // Hazard terms are qualified with rst_ni so every control drops as soon as
  // reset asserts, even while the inputs are still driven.
  always_comb begin
    mstall = 1'b0;
    unique case (state_q)
      StRun:     mstall = MemReqM_i && !MemReadyM_i;
      StMemWait: mstall = !MemReadyM_i && (wait_cnt_q != TimeoutVal);
      default:   mstall = 1'b0;
    endcase
    mstall  = mstall && rst_ni;
    lwstall = rst_ni && LoadE_i && (RdE_i != '0) && ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
    branch  = rst_ni && PCSrcE_i;
  end

  // Memory-wait FSM. MemReqM_i is not looked at in StMemWait: M is held, so
  // the request is still the same access.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      StRun: begin
        if (MemReqM_i && !MemReadyM_i) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (MemReadyM_i) begin
          state_d = StRun;
        end else if (wait_cnt_q == TimeoutVal) begin
          // Give up: the access is treated as complete and the flag latches.
          timeout_d = 1'b1;
          state_d   = StRun;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Stall / flush priority: memory stall, then redirect, then load-use.
  // Under a memory stall a pending redirect or load-use simply waits, since
  // the E stage is held and presents the same condition on release.
  always_comb begin
    StallF_o = 1'b0;
    StallD_o = 1'b0;
    StallE_o = 1'b0;
    StallM_o = 1'b0;
    FlushD_o = 1'b0;
    FlushE_o = 1'b0;
    FlushW_o = 1'b0;
    if (mstall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else if (branch) begin
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
    end else if (lwstall) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      FlushE_o = 1'b1;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                         input logic [REG_ADDR_WIDTH-1:0] rd_m,
                                         input logic                      we_m,
                                         input logic [REG_ADDR_WIDTH-1:0] rd_w,
                                         input logic                      we_w);
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (rst_ni) begin
      ForwardAE_o = fwd_sel(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
      ForwardBE_o = fwd_sel(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
    end
  end

  // Performance counters, saturating at all-ones.
  always_comb begin
    stall_inc   = mstall || (lwstall && !branch);
    flush_inc   = branch && !mstall;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemTimeout_o  = timeout_q;
  assign StallCycles_o = stall_cnt_q;
  assign FlushCount_o  = flush_cnt_q;

endmodule
